// File: rtl/imem_loadable.sv
// Loadable instruction memory: reset-time clear sequencer plus a byte-stream loader.
// Fetches are combinational; the core is stalled and fed FILL while contents are in flux.
module imem_loadable #(
  parameter int          DEPTH = 32,
  parameter logic [31:0] FILL  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  output logic [31:0] instruction,
  output logic        fetch_fault,
  output logic        core_stall,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        load_done,
  output logic        load_err
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_HDR0  = 3'd2;
  localparam logic [2:0] S_HDR1  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [IW:0] CLR_LAST = (IW + 1)'(DEPTH - 1);
  localparam logic [IW:0] CLR_ONE  = (IW + 1)'(1);

  logic [2:0]    state;
  logic [IW:0]   clr_idx;
  logic [15:0]   count;
  logic [16:0]   word_idx;
  logic [1:0]    lane;
  logic [23:0]   word_buf;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          word_fits;
  logic          last_word;
  logic [31:0]   word_full;
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          addr_in_range;

  assign ld_ready  = !reset && (state == S_HDR0 || state == S_HDR1 || state == S_DATA);
  assign accept    = ld_valid && ld_ready;
  assign word_full = {ld_data, word_buf};
  // word_idx is one bit wider than count so the overflow comparison cannot wrap
  assign word_fits = {15'd0, word_idx} < DEPTH_W;
  assign last_word = (word_idx + 17'd1) == {1'b0, count};

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = FILL;
    if (!reset) begin
      if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx[IW-1:0];
      end else if (state == S_DATA && accept && lane == 2'd3 && word_fits) begin
        mem_we    = 1'b1;
        mem_waddr = word_idx[IW-1:0];
        mem_wdata = word_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Lanes 0..2 are held here; lane 3 arrives straight from ld_data on the write edge
  always_ff @(posedge clk) begin
    if (state == S_DATA && accept) begin
      case (lane)
        2'd0:    word_buf[7:0]   <= ld_data;
        2'd1:    word_buf[15:8]  <= ld_data;
        2'd2:    word_buf[23:16] <= ld_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLEAR;
      clr_idx   <= '0;
      count     <= 16'd0;
      word_idx  <= 17'd0;
      lane      <= 2'd0;
      load_err  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + CLR_ONE;
          if (clr_idx == CLR_LAST) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (ld_start) begin
            state    <= S_HDR0;
            load_err <= 1'b0;
          end
        end
        S_HDR0: begin
          if (accept) begin
            count[7:0] <= ld_data;
            state      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept) begin
            count[15:8] <= ld_data;
            if ({ld_data, count[7:0]} == 16'd0) begin
              state     <= S_IDLE;
              load_done <= 1'b1;
            end else begin
              state    <= S_DATA;
              word_idx <= 17'd0;
              lane     <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              if (!word_fits) begin
                load_err <= 1'b1;
              end
              word_idx <= word_idx + 17'd1;
              if (last_word) begin
                state     <= S_IDLE;
                load_done <= 1'b1;
              end
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign core_stall    = reset || (state != S_IDLE);
  assign addr_in_range = {2'b00, addr[31:2]} < DEPTH_W;
  assign fetch_fault   = (addr[1:0] != 2'b00) || !addr_in_range;

  always_comb begin
    instruction = FILL;
    if (!core_stall && addr_in_range) begin
      instruction = mem[addr[IW+1:2]];
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: DEPTH=32 and DEPTH=4 instances share one stimulus stream,
// each compared against an array model of what the memory should hold.
module tb_imem_loadable;

  localparam logic [31:0] FILL = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, ld_start, ld_valid;
  logic [7:0]  ld_data;
  logic [31:0] addr;

  logic [31:0] instr_a, instr_b;
  logic        fault_a, fault_b, stall_a, stall_b;
  logic        ready_a, ready_b, done_a, done_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_a [32];
  logic [31:0] ref_b [4];
  bit          err_ref_a, err_ref_b;
  int          done_cnt_a = 0, done_cnt_b = 0;
  logic [31:0] wq [$];

  always #5 clk = ~clk;

  imem_loadable #(.DEPTH(32), .FILL(FILL)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .instruction(instr_a),
    .fetch_fault(fault_a), .core_stall(stall_a), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ready_a),
    .load_done(done_a), .load_err(err_a)
  );

  imem_loadable #(.DEPTH(4), .FILL(FILL)) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .instruction(instr_b),
    .fetch_fault(fault_b), .core_stall(stall_b), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ready_b),
    .load_done(done_b), .load_err(err_b)
  );

  always @(posedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 32; i++) ref_a[i] = FILL;
    for (int i = 0; i < 4; i++) ref_b[i] = FILL;
    err_ref_a = 1'b0;
    err_ref_b = 1'b0;
  endtask

  // Releases reset and checks each instance stays stalled for exactly DEPTH edges
  task automatic release_and_clear;
    int fa, fb;
    fa = -1;
    fb = -1;
    reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (stall_a === 1'b0 && fa < 0) fa = c;
      if (stall_b === 1'b0 && fb < 0) fb = c;
    end
    model_clear();
    checks++;
    if (fa !== 32) begin errors++; $display("FAIL clear_len_a: got %0d cycles, expected 32", fa); end
    checks++;
    if (fb !== 4) begin errors++; $display("FAIL clear_len_b: got %0d cycles, expected 4", fb); end
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] exp_a, exp_b;
    int bad_a, bad_b, badf;
    bad_a = 0; bad_b = 0; badf = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      addr = 32'(i * 4);
      #1;
      exp_a = (i < 32) ? ref_a[i] : FILL;
      exp_b = (i < 4) ? ref_b[i] : FILL;
      if (instr_a !== exp_a) begin
        bad_a++;
        $display("FAIL %s mem_a[%0d]: got %h expected %h", tag, i, instr_a, exp_a);
      end
      if (instr_b !== exp_b) begin
        bad_b++;
        $display("FAIL %s mem_b[%0d]: got %h expected %h", tag, i, instr_b, exp_b);
      end
      if (fault_a !== (i >= 32) || fault_b !== (i >= 4)) begin
        badf++;
        $display("FAIL %s fault[%0d]: got %b/%b expected %b/%b", tag, i, fault_a, fault_b, i >= 32, i >= 4);
      end
    end
    checks += 3;
    if (bad_a != 0) errors++;
    if (bad_b != 0) errors++;
    if (badf != 0) errors++;
    checks++;
    if (err_a !== err_ref_a) begin errors++; $display("FAIL %s load_err_a: got %b expected %b", tag, err_a, err_ref_a); end
    checks++;
    if (err_b !== err_ref_b) begin errors++; $display("FAIL %s load_err_b: got %b expected %b", tag, err_b, err_ref_b); end
    tick();
  endtask

  // Sends one session for the words in wq; gap idle cycles between bytes
  task automatic run_session(input string tag, input int gap, input bit valid_on_start);
    logic [7:0] bytes [$];
    logic [15:0] cnt;
    int d0a, d0b, bad_stall, bad_ready;
    cnt = 16'(wq.size());
    bytes.push_back(cnt[7:0]);
    bytes.push_back(cnt[15:8]);
    foreach (wq[w]) for (int l = 0; l < 4; l++) bytes.push_back(8'(wq[w] >> (8 * l)));
    d0a = done_cnt_a;
    d0b = done_cnt_b;
    bad_stall = 0;
    bad_ready = 0;

    ld_start = 1'b1;
    ld_valid = valid_on_start;
    ld_data  = 8'h05;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    checks++;
    if (ready_a !== 1'b1 || stall_a !== 1'b1 || err_a !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL %s start: ready=%b stall=%b err=%b/%b expected 1 1 0/0", tag, ready_a, stall_a, err_a, err_b);
    end

    for (int k = 0; k < bytes.size(); k++) begin
      if (ready_a !== 1'b1 || ready_b !== 1'b1) bad_ready++;
      ld_valid = 1'b1;
      ld_data  = bytes[k];
      tick();
      ld_valid = 1'b0;
      if (k != bytes.size() - 1) begin
        if (stall_a !== 1'b1 || stall_b !== 1'b1) bad_stall++;
        for (int g = 0; g < gap; g++) begin
          tick();
          if (stall_a !== 1'b1 || stall_b !== 1'b1) bad_stall++;
        end
      end
    end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL %s ready_during_session: got %0d low cycles, expected 0", tag, bad_ready); end
    checks++;
    if (bad_stall != 0) begin errors++; $display("FAIL %s stall_during_session: got %0d low cycles, expected 0", tag, bad_stall); end
    checks++;
    if (done_a !== 1'b1 || done_b !== 1'b1 || stall_a !== 1'b0 || stall_b !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b/%b stall=%b/%b expected 1/1 0/0", tag, done_a, done_b, stall_a, stall_b);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || done_cnt_a - d0a != 1 || done_cnt_b - d0b != 1) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b pulses=%0d/%0d expected 0 1/1", tag, done_a, done_cnt_a - d0a, done_cnt_b - d0b);
    end

    for (int i = 0; i < wq.size(); i++) begin
      if (i < 32) ref_a[i] = wq[i];
      if (i < 4) ref_b[i] = wq[i];
    end
    err_ref_a = wq.size() > 32;
    err_ref_b = wq.size() > 4;
    check_mem(tag);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (stall_a !== 1'b1 || stall_b !== 1'b1 || ready_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || instr_a !== FILL) begin
      errors++;
      $display("FAIL reset_values: stall=%b/%b ready=%b done=%b err=%b instr=%h", stall_a, stall_b, ready_a, done_a, err_a, instr_a);
    end
    release_and_clear();
    check_mem("after_clear");
    @(negedge clk);
    addr = 32'd128;
    #1;
    checks++;
    if (instr_a !== FILL || fault_a !== 1'b1) begin
      errors++;
      $display("FAIL addr128: got %h fault=%b expected %h fault=1", instr_a, fault_a, FILL);
    end
    tick();
  endtask

  task automatic test_basic_load;
    wq = '{32'h00A00513, 32'h02000063};
    run_session("basic", 0, 1'b0);
  endtask

  task automatic test_gapped_load;
    reset = 1'b1;
    repeat (2) tick();
    release_and_clear();
    wq = '{32'h00A00513, 32'h02000063};
    run_session("gapped", 1, 1'b0);
  endtask

  task automatic test_overflow;
    wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_session("overflow", 0, 1'b0);
  endtask

  task automatic test_zero_count;
    wq.delete();
    run_session("zero_count", 0, 1'b0);
    @(negedge clk);
    addr = 32'd2;
    #1;
    checks++;
    if (fault_a !== 1'b1 || instr_a !== ref_a[0]) begin
      errors++;
      $display("FAIL misaligned: got %h fault=%b expected %h fault=1", instr_a, fault_a, ref_a[0]);
    end
    tick();
  endtask

  task automatic test_start_with_valid;
    wq = '{$urandom()};
    run_session("start_with_valid", 0, 1'b1);
  endtask

  task automatic test_random;
    for (int s = 0; s < 5; s++) begin
      wq.delete();
      for (int i = 0, n = $urandom_range(7, 1); i < n; i++) wq.push_back($urandom());
      run_session("random", int'($urandom_range(1, 0)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] bytes [7];
    int d0a, d0b;
    bytes = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    d0a = done_cnt_a;
    d0b = done_cnt_b;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    foreach (bytes[k]) begin
      ld_valid = 1'b1;
      ld_data  = bytes[k];
      tick();
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    release_and_clear();
    checks++;
    if (done_cnt_a != d0a || done_cnt_b != d0b) begin
      errors++;
      $display("FAIL reset_mid_load_done: got %0d/%0d pulses expected 0/0", done_cnt_a - d0a, done_cnt_b - d0b);
    end
    check_mem("reset_mid_load");
  endtask

  initial begin
    reset    = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    addr     = 32'd0;
    model_clear();
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_overflow();
    test_zero_count();
    test_start_with_valid();
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
